// File: rtl/fifo_param_pkg.sv
// Shared defaults and helpers for the parametrised per-lane FIFO.
// Depth is always a power of two derived from the pointer width.
package fifo_param_pkg;

  localparam int DEF_DATA_WIDTH   = 10;
  localparam int DEF_ADDR_WIDTH   = 3;
  localparam int DEF_ALMOST_FULL  = 6;
  localparam int DEF_ALMOST_EMPTY = 2;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int count_width_of(input int addr_width);
    return addr_width + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_param_memoria_dp.sv
// Dual-port register array: one write port, one registered read port.
// Storage has no reset; only the read-data register can be cleared.
module memoria_dp
  import fifo_param_pkg::*;
#(
  parameter int data_width    = DEF_DATA_WIDTH,
  parameter int address_width = DEF_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rd_clr_i,
  input  logic                     wr_en_i,
  input  logic [address_width-1:0] wr_addr_i,
  input  logic [data_width-1:0]    wr_data_i,
  input  logic                     rd_en_i,
  input  logic [address_width-1:0] rd_addr_i,
  output logic [data_width-1:0]    rd_data_o
);

  localparam int DEPTH = depth_of(address_width);

  logic [data_width-1:0] mem_q [DEPTH];
  logic [data_width-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Same-address read and write returns the old word (read-before-write).
  always_ff @(posedge clk) begin
    if (rd_clr_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with owned pointers, occupancy counter,
// programmable almost flags, sticky error flags and a registered read port.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int data_width       = DEF_DATA_WIDTH,
  parameter int address_width    = DEF_ADDR_WIDTH,
  parameter int almost_full_lvl  = DEF_ALMOST_FULL,
  parameter int almost_empty_lvl = DEF_ALMOST_EMPTY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_enable,
  input  logic                   rd_enable,
  input  logic [data_width-1:0]  FIFO_data_in,
  output logic [data_width-1:0]  FIFO_data_out,
  output logic                   data_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [address_width:0] fifo_count,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int CW = count_width_of(address_width);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth_of(address_width));
  localparam logic [CW-1:0] AF_C    = CW'(almost_full_lvl);
  localparam logic [CW-1:0] AE_C    = CW'(almost_empty_lvl);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     valid_q, valid_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     wr_accept, rd_accept;
  fifo_flags_t              flags;

  always_comb begin
    flags              = '0;
    flags.full         = (count_q == DEPTH_C);
    flags.empty        = (count_q == '0);
    flags.almost_full  = (count_q >= AF_C);
    flags.almost_empty = (count_q <= AE_C);
  end

  // A write into a full FIFO is still taken when a read frees a slot the same edge.
  assign rd_accept = rd_enable & ~flags.empty;
  assign wr_accept = wr_enable & (~flags.full | rd_accept);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = rd_accept;
    ovf_d    = ovf_q | (wr_enable & ~wr_accept);
    unf_d    = unf_q | (rd_enable & flags.empty);
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  memoria_dp #(
    .data_width   (data_width),
    .address_width(address_width)
  ) u_mem (
    .clk      (clk),
    .rd_clr_i (reset),
    .wr_en_i  (wr_accept & ~reset),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(FIFO_data_in),
    .rd_en_i  (rd_accept),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(FIFO_data_out)
  );

  assign data_valid    = valid_q;
  assign fifo_count    = count_q;
  assign full          = flags.full;
  assign empty         = flags.empty;
  assign almost_full   = flags.almost_full;
  assign almost_empty  = flags.almost_empty;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed scenarios then random traffic, every cycle
// compared against a queue-based reference model.
module tb_fifo_param;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int DEPTH = 1 << AW;

  if (!(AE > 0 && AE < AF && AF < DEPTH)) begin : g_bad_params
    initial $fatal(1, "FAIL params: almost levels illegal for depth %0d", DEPTH);
  end

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_enable = 1'b0;
  logic          rd_enable = 1'b0;
  logic [DW-1:0] FIFO_data_in = '0;
  logic [DW-1:0] FIFO_data_out;
  logic          data_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   fifo_count;
  logic          err_overflow, err_underflow;

  fifo_param #(
    .data_width      (DW),
    .address_width   (AW),
    .almost_full_lvl (AF),
    .almost_empty_lvl(AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_enable    (wr_enable),
    .rd_enable    (rd_enable),
    .FIFO_data_in (FIFO_data_in),
    .FIFO_data_out(FIFO_data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_out;
  logic          exp_valid;
  logic          exp_ovf, exp_unf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_update(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    logic rd_ok, wr_ok;
    if (r) begin
      exp_q.delete();
      exp_out   = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      rd_ok = rd && (exp_q.size() > 0);
      wr_ok = w && ((exp_q.size() < DEPTH) || rd_ok);
      exp_valid = rd_ok;
      if (rd_ok) exp_out = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
      if (w && !wr_ok) exp_ovf = 1'b1;
      if (rd && !rd_ok) exp_unf = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = exp_q.size();
    check("data_valid", 32'(data_valid), 32'(exp_valid));
    check("data_out", 32'(FIFO_data_out), 32'(exp_out));
    check("count", 32'(fifo_count), 32'(sz));
    check("full", 32'(full), 32'(sz == DEPTH));
    check("empty", 32'(empty), 32'(sz == 0));
    check("almost_full", 32'(almost_full), 32'(sz >= AF));
    check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    check("err_overflow", 32'(err_overflow), 32'(exp_ovf));
    check("err_underflow", 32'(err_underflow), 32'(exp_unf));
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    reset        = r;
    wr_enable    = w;
    rd_enable    = rd;
    FIFO_data_in = d;
    @(posedge clk);
    model_update(r, w, rd, d);
    #1;
    check_all();
  endtask

  logic [DW-1:0] fill_words [8];

  initial begin
    fill_words[0] = 10'h3C5; fill_words[1] = 10'h3FF;
    fill_words[2] = 10'h30B; fill_words[3] = 10'h36C;
    fill_words[4] = 10'h1A1; fill_words[5] = 10'h395;
    fill_words[6] = 10'h3BF; fill_words[7] = 10'h302;
    exp_out = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;

    // Reset held two cycles
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Fill, then overflow with a word that must never come out
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, fill_words[i]);
    step(1'b0, 1'b1, 1'b0, 10'h379);

    // Drain in order, then one idle cycle so the last word's valid drops
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    // Refill across the pointer wrap, simultaneous wr+rd at full
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom_range(0, 1023)));
    step(1'b0, 1'b1, 1'b1, 10'h155);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, '0);

    // Simultaneous wr+rd at empty: write only, underflow flagged
    step(1'b0, 1'b1, 1'b1, 10'h0F0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Mid-operation reset with five words stored
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom_range(0, 1023)));
    step(1'b1, 1'b1, 1'b1, 10'h111);
    step(1'b0, 1'b1, 1'b0, 10'h2AA);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    // Random traffic: write-heavy, read-heavy, then balanced with rare resets
    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      logic r;
      wp = (i < 200) ? 75 : (i < 400) ? 25 : 50;
      rp = (i < 200) ? 25 : (i < 400) ? 75 : 50;
      r  = ($urandom_range(0, 99) < 2);
      step(r, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
           DW'($urandom_range(0, 1023)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
